// File: rtl/multi_queue_ram_if.sv
// Bundle of per-queue push/pop, threshold and status signals for multi_queue_ram.
// Buses are packed [NUM_QUEUES-1:0][width-1:0], so slice q sits at bits [q*width +: width].
interface multi_queue_ram_if #(
  parameter int DATA_SIZE     = 8,
  parameter int QUEUE_LENGTH  = 4,
  parameter int NUM_QUEUES    = 4,
  parameter int REGISTER_SIZE = 32
);
  localparam int CW = $clog2(QUEUE_LENGTH) + 1;

  logic [NUM_QUEUES-1:0]                    push_valid;
  logic [NUM_QUEUES-1:0][DATA_SIZE-1:0]     push_data;
  logic [NUM_QUEUES-1:0]                    pop;
  logic [NUM_QUEUES-1:0][REGISTER_SIZE-1:0] higher_threshold;
  logic [NUM_QUEUES-1:0][REGISTER_SIZE-1:0] lower_threshold;
  logic                                     clear_errors;
  logic [NUM_QUEUES-1:0][DATA_SIZE-1:0]     value_out;
  logic [NUM_QUEUES-1:0][CW-1:0]            count;
  logic [NUM_QUEUES-1:0]                    empty;
  logic [NUM_QUEUES-1:0]                    full;
  logic [NUM_QUEUES-1:0]                    last_elem;
  logic [NUM_QUEUES-1:0]                    kill_the_core;
  logic [NUM_QUEUES-1:0]                    overflow;
  logic [NUM_QUEUES-1:0]                    underflow;

  modport master (
    output push_valid, push_data, pop, higher_threshold, lower_threshold, clear_errors,
    input  value_out, count, empty, full, last_elem, kill_the_core, overflow, underflow
  );
  modport slave (
    input  push_valid, push_data, pop, higher_threshold, lower_threshold, clear_errors,
    output value_out, count, empty, full, last_elem, kill_the_core, overflow, underflow
  );
endinterface

// File: rtl/multi_queue_ram.sv
// NUM_QUEUES independent circular FIFOs with occupancy flags, sticky errors and a
// hysteretic kill_the_core throttle; one mq_lane instance per queue.
module mq_lane #(
  parameter int DATA_SIZE     = 8,
  parameter int QUEUE_LENGTH  = 4,
  parameter int REGISTER_SIZE = 32,
  parameter int INIT_COUNTER  = 0,
  parameter int CW            = $clog2(QUEUE_LENGTH) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_valid,
  input  logic [DATA_SIZE-1:0]     push_data,
  input  logic                     pop,
  input  logic [REGISTER_SIZE-1:0] higher_threshold,
  input  logic [REGISTER_SIZE-1:0] lower_threshold,
  input  logic                     clear_errors,
  output logic [DATA_SIZE-1:0]     value_out,
  output logic [CW-1:0]            count,
  output logic                     empty,
  output logic                     full,
  output logic                     last_elem,
  output logic                     kill_the_core,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int PW = $clog2(QUEUE_LENGTH);
  localparam logic [PW-1:0] TAIL_RST = (INIT_COUNTER == QUEUE_LENGTH) ? '0 : PW'(INIT_COUNTER);
  localparam logic [CW-1:0] QL_C     = CW'(QUEUE_LENGTH);

  logic [QUEUE_LENGTH-1:0][DATA_SIZE-1:0] mem;
  logic [PW-1:0]            head, tail;
  logic                     pop_acc, push_acc, ovf_set, unf_set, kill_next;
  logic [CW-1:0]            count_next;
  logic [REGISTER_SIZE-1:0] cn_ext;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_LENGTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop frees a slot this cycle, so a full queue still accepts a same-cycle push.
  always_comb begin
    pop_acc    = pop && (count != '0);
    push_acc   = push_valid && ((count != QL_C) || pop_acc);
    count_next = count + CW'(push_acc) - CW'(pop_acc);
    cn_ext     = REGISTER_SIZE'(count_next);
    ovf_set    = push_valid && (count == QL_C) && !pop_acc;
    unf_set    = pop && (count == '0);
    kill_next  = kill_the_core;
    if (higher_threshold == '0)             kill_next = 1'b0;
    else if (cn_ext >= higher_threshold)    kill_next = 1'b1;
    else if (cn_ext <= lower_threshold)     kill_next = 1'b0;
  end

  assign value_out = (count == '0) ? '0 : mem[head];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_LENGTH; i++)
        mem[i] <= (i < INIT_COUNTER) ? DATA_SIZE'(i) : '0;
      head          <= '0;
      tail          <= TAIL_RST;
      count         <= CW'(INIT_COUNTER);
      empty         <= (INIT_COUNTER == 0);
      full          <= (INIT_COUNTER == QUEUE_LENGTH);
      last_elem     <= (INIT_COUNTER == 1);
      kill_the_core <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      // Push is written after the vacate so it wins when both hit the same slot.
      if (pop_acc) begin
        mem[head] <= '0;
        head      <= nxt(head);
      end
      if (push_acc) begin
        mem[tail] <= push_data;
        tail      <= nxt(tail);
      end
      count         <= count_next;
      empty         <= (count_next == '0);
      full          <= (count_next == QL_C);
      last_elem     <= (count_next == CW'(1));
      kill_the_core <= kill_next;
      overflow      <= (overflow  & ~clear_errors) | ovf_set;
      underflow     <= (underflow & ~clear_errors) | unf_set;
    end
  end
endmodule

module multi_queue_ram #(
  parameter int DATA_SIZE     = 8,
  parameter int QUEUE_LENGTH  = 4,
  parameter int NUM_QUEUES    = 4,
  parameter int REGISTER_SIZE = 32,
  parameter int INIT_COUNTER  = 0
) (
  input  logic               clock,
  input  logic               reset,
  multi_queue_ram_if.slave   bus
);
  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_q
    mq_lane #(
      .DATA_SIZE(DATA_SIZE), .QUEUE_LENGTH(QUEUE_LENGTH),
      .REGISTER_SIZE(REGISTER_SIZE), .INIT_COUNTER(INIT_COUNTER)
    ) u_lane (
      .clock           (clock),
      .reset           (reset),
      .push_valid      (bus.push_valid[q]),
      .push_data       (bus.push_data[q]),
      .pop             (bus.pop[q]),
      .higher_threshold(bus.higher_threshold[q]),
      .lower_threshold (bus.lower_threshold[q]),
      .clear_errors    (bus.clear_errors),
      .value_out       (bus.value_out[q]),
      .count           (bus.count[q]),
      .empty           (bus.empty[q]),
      .full            (bus.full[q]),
      .last_elem       (bus.last_elem[q]),
      .kill_the_core   (bus.kill_the_core[q]),
      .overflow        (bus.overflow[q]),
      .underflow       (bus.underflow[q])
    );
  end
endmodule

// File: tb/tb_multi_queue_ram.sv
// Scoreboarded random + directed bench for multi_queue_ram against a queue-based model.
module tb_multi_queue_ram;
  localparam int DS = 8, QL = 4, NQ = 4, RS = 32, INIT = 2;
  localparam int CW = $clog2(QL) + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  multi_queue_ram_if #(.DATA_SIZE(DS), .QUEUE_LENGTH(QL), .NUM_QUEUES(NQ), .REGISTER_SIZE(RS)) bus();

  multi_queue_ram #(.DATA_SIZE(DS), .QUEUE_LENGTH(QL), .NUM_QUEUES(NQ),
                    .REGISTER_SIZE(RS), .INIT_COUNTER(INIT)) dut (
    .clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic [NQ-1:0][DS-1:0] v;
    logic [NQ-1:0][CW-1:0] c;
    logic [NQ-1:0] e, f, l, k, o, u;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  int   total = 0, bad = 0;

  // Reference model: plain queues of entries plus flag bits.
  int mq[NQ][$];
  bit mk[NQ], mo[NQ], mu[NQ];
  int hi[NQ], lo[NQ];

  task automatic chk(input string nm, input int q, input logic [31:0] act, input logic [31:0] ex);
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s q%0d t=%0t got=%h want=%h", nm, q, $time, act, ex);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      mon_x = sb.pop_front();
      for (int q = 0; q < NQ; q++) begin
        chk("value_out", q, 32'(bus.value_out[q]),     32'(mon_x.v[q]));
        chk("count",     q, 32'(bus.count[q]),         32'(mon_x.c[q]));
        chk("empty",     q, 32'(bus.empty[q]),         32'(mon_x.e[q]));
        chk("full",      q, 32'(bus.full[q]),          32'(mon_x.f[q]));
        chk("last_elem", q, 32'(bus.last_elem[q]),     32'(mon_x.l[q]));
        chk("kill",      q, 32'(bus.kill_the_core[q]), 32'(mon_x.k[q]));
        chk("overflow",  q, 32'(bus.overflow[q]),      32'(mon_x.o[q]));
        chk("underflow", q, 32'(bus.underflow[q]),     32'(mon_x.u[q]));
      end
    end
  end

  task automatic step(input logic [NQ-1:0] pv, input logic [NQ-1:0][DS-1:0] pd,
                      input logic [NQ-1:0] pp, input bit clr, input bit rst);
    exp_t x;
    @(negedge clock);
    reset = rst;
    bus.push_valid = pv; bus.push_data = pd; bus.pop = pp; bus.clear_errors = clr;
    for (int q = 0; q < NQ; q++) begin
      bus.higher_threshold[q] = RS'(hi[q]);
      bus.lower_threshold[q]  = RS'(lo[q]);
    end
    for (int q = 0; q < NQ; q++) begin
      if (rst) begin
        mq[q].delete();
        for (int i = 0; i < INIT; i++) mq[q].push_back(i);
        mk[q] = 0; mo[q] = 0; mu[q] = 0;
      end else begin
        bit pa, pu, on, un;
        int n;
        pa = pp[q] && mq[q].size() > 0;
        pu = pv[q] && (mq[q].size() < QL || pa);
        on = pv[q] && mq[q].size() == QL && !pa;
        un = pp[q] && mq[q].size() == 0;
        if (pa) void'(mq[q].pop_front());
        if (pu) mq[q].push_back(int'(pd[q]));
        n = mq[q].size();
        if (hi[q] == 0)       mk[q] = 0;
        else if (n >= hi[q])  mk[q] = 1;
        else if (n <= lo[q])  mk[q] = 0;
        mo[q] = (mo[q] && !clr) || on;
        mu[q] = (mu[q] && !clr) || un;
      end
      x.c[q] = CW'(mq[q].size());
      x.v[q] = (mq[q].size() > 0) ? DS'(mq[q][0]) : '0;
      x.e[q] = mq[q].size() == 0;
      x.f[q] = mq[q].size() == QL;
      x.l[q] = mq[q].size() == 1;
      x.k[q] = mk[q]; x.o[q] = mo[q]; x.u[q] = mu[q];
    end
    sb.push_back(x);
  endtask

  // Single-queue operation helper; other queues idle.
  task automatic op(input int q, input bit dp, input logic [DS-1:0] d, input bit dq, input bit clr);
    logic [NQ-1:0] pv, pp;
    logic [NQ-1:0][DS-1:0] pd;
    pv = '0; pp = '0; pd = '0;
    pv[q] = dp; pp[q] = dq; pd[q] = d;
    step(pv, pd, pp, clr, 1'b0);
  endtask

  initial begin
    logic [NQ-1:0][DS-1:0] rd;
    logic [NQ-1:0] rv, rp;
    bus.push_valid = '0; bus.push_data = '0; bus.pop = '0; bus.clear_errors = 1'b0;
    bus.higher_threshold = '0; bus.lower_threshold = '0;
    for (int q = 0; q < NQ; q++) begin hi[q] = 0; lo[q] = 0; end

    // Preloaded reset, then drain every queue
    step('0, '0, '0, 1'b0, 1'b1);
    step('0, '0, '0, 1'b0, 1'b1);
    step('0, '0, '1, 1'b0, 1'b0);
    step('0, '0, '1, 1'b0, 1'b0);

    // Queue 1: fill, overflow, drain
    for (int i = 1; i <= 5; i++) op(1, 1, DS'(8'hA0 + i), 0, 0);
    for (int i = 0; i < 4; i++)  op(1, 0, '0, 1, 0);

    // Queue 0: fill then push+pop while full, wrap pointers
    for (int i = 0; i < 4; i++)  op(0, 1, DS'(8'h10 + i), 0, 0);
    op(0, 1, 8'h55, 1, 0);
    for (int i = 0; i < 4; i++)  op(0, 0, '0, 1, 0);

    // Queue 2: underflow, push+pop on empty, clear
    op(2, 0, '0, 1, 0);
    op(2, 1, 8'h3C, 1, 0);
    op(2, 0, '0, 0, 1);
    op(2, 0, '0, 1, 0);

    // Queue 3: kill hysteresis
    hi[3] = 3; lo[3] = 1;
    for (int i = 0; i < 3; i++) op(3, 1, DS'(8'h70 + i), 0, 0);
    op(3, 0, '0, 1, 0);
    op(3, 0, '0, 1, 0);
    hi[3] = 0;
    op(3, 0, '0, 0, 0);

    // Reset with pushes pending everywhere
    for (int q = 0; q < NQ; q++) rd[q] = DS'($urandom);
    step('1, rd, '0, 1'b0, 1'b0);
    step('1, rd, '0, 1'b0, 1'b1);
    step('0, '0, '0, 1'b0, 1'b0);

    // Random traffic, phases biased toward filling and draining
    for (int n = 0; n < 600; n++) begin
      int bias;
      bias = ((n / 40) % 2 == 0) ? 75 : 25;
      if (n % 50 == 0)
        for (int q = 0; q < NQ; q++) begin
          hi[q] = $urandom_range(0, 5);
          lo[q] = $urandom_range(0, 4);
        end
      for (int q = 0; q < NQ; q++) begin
        rv[q] = $urandom_range(0, 99) < bias;
        rp[q] = $urandom_range(0, 99) < (100 - bias);
        rd[q] = DS'($urandom);
      end
      step(rv, rd, rp, $urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0);
    end

    step('0, '0, '0, 1'b0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_queue_ram.md
# multi_queue_ram

`multi_queue_ram` holds NUM_QUEUES independent circular FIFOs, one per core or request class, in a single register array. Each FIFO has its own occupancy counter, full/empty flags and sticky overflow/underflow error flags. Each FIFO also drives a registered per-queue `kill_the_core` throttle with hysteresis. It sits in the MemorEDF scheduler between the per-core request intake and the EDF arbiter, which pops the head of the selected queue.

## Interface
- `DATA_SIZE`, 8, width of one entry.
- `QUEUE_LENGTH`, 4, entries per queue; any value ≥ 2, power of two not required.
- `NUM_QUEUES`, 4, number of independent queues.
- `REGISTER_SIZE`, 32, width of each threshold field.
- `INIT_COUNTER`, 0, entries preloaded per queue at reset; 0 ≤ INIT_COUNTER ≤ QUEUE_LENGTH.
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `push_valid`  in  NUM_QUEUES  bit q = write `push_data` slice q into queue q.
- `push_data`  in  NUM_QUEUES*DATA_SIZE  slice q = bits [q*DATA_SIZE +: DATA_SIZE].
- `pop`  in  NUM_QUEUES  bit q = consume the head of queue q.
- `higher_threshold`  in  NUM_QUEUES*REGISTER_SIZE  per-queue kill-set level; 0 disables kill.
- `lower_threshold`  in  NUM_QUEUES*REGISTER_SIZE  per-queue kill-release level.
- `clear_errors`  in  1  clears all sticky error flags.
- `value_out`  out  NUM_QUEUES*DATA_SIZE  head entry per queue; 0 when that queue is empty.
- `count`  out  NUM_QUEUES*($clog2(QUEUE_LENGTH)+1)  per-queue occupancy.
- `empty`, `full`, `last_elem`  out  NUM_QUEUES  per-queue registered flags; `last_elem` means count == 1.
- `kill_the_core`  out  NUM_QUEUES  per-queue registered throttle.
- `overflow`, `underflow`  out  NUM_QUEUES  sticky error flags.

## Operation
- Per-queue state: storage [QUEUE_LENGTH], `head` (next read slot), `tail` (next write slot), `count`.
- Pointer advance: wrap explicitly, p == QUEUE_LENGTH-1 → 0, else p+1. The design uses no modulo operator.
- `value_out[q]` is combinational: mem[q][head[q]] when not empty, else 0.
- Accepted push = push_valid & (!full | pop_accepted).
  - Write mem[tail], advance tail.
- Accepted pop = pop & !empty.
  - Advance head; the vacated slot is written 0, unless the same slot is written by an accepted push in the same cycle, in which case the push wins.
- count_next = count + push_acc − pop_acc.
  - Both accepted: count is unchanged.
  - Count never exceeds QUEUE_LENGTH and never drops below 0.
- Push to a full queue without a pop: data is dropped, state is unchanged, `overflow[q]` is set.
  - Full queue with simultaneous push and pop: both are accepted and no overflow is flagged.
- Pop of an empty queue: `underflow[q]` is set.
  - On an empty queue, simultaneous push and pop: the push is accepted, the pop is ignored, underflow is set, and count becomes 1.
- `clear_errors` clears all error flags. If a new error occurs in the same cycle, set wins.
- Flags are computed from count_next and registered: empty = (count_next == 0), full = (count_next == QUEUE_LENGTH), last_elem = (count_next == 1).
- Kill per queue is evaluated on count_next, zero-extended to REGISTER_SIZE:
  - If higher_threshold == 0, kill is forced to 0.
  - Else, if count_next ≥ higher_threshold, kill is set.
  - Else, if count_next ≤ lower_threshold, kill is cleared.
  - Otherwise kill holds its value.
- Queues are fully independent; no cross-queue interaction.

## Timing
- Reset, every queue:
  - mem[i] = i for i < INIT_COUNTER, 0 otherwise.
  - head = 0, tail = INIT_COUNTER wrapped to 0 if equal to QUEUE_LENGTH, count = INIT_COUNTER.
  - empty = (INIT_COUNTER == 0), full = (INIT_COUNTER == QUEUE_LENGTH), last_elem = (INIT_COUNTER == 1).
  - kill_the_core = 0, overflow = 0, underflow = 0.
- Reset takes priority over push and pop in the same cycle. Reset mid-operation discards all contents and restores the preload.
- Push at edge N: the data is visible on `value_out` (if it becomes the head) and in `count` and the flags after edge N. Push-to-read latency is one cycle.
- Pop at edge N: the new head is visible after edge N.
- Kill latency: one edge after the push or pop that crosses the threshold. Threshold input changes take effect at the next edge.
- Sustained throughput: one push and one pop per queue per cycle.

## Test plan
- Reset with INIT_COUNTER=2, QUEUE_LENGTH=4 → every queue count=2, value_out=0, empty=0, full=0. Two pops → value_out shows 1, then 0 with empty=1.
- Queue 1: push 0xA1..0xA4, then push 0xA5 → full=1 after the 4th push. 0xA5 is dropped and overflow[1]=1. Pops return A1..A4. Other queues stay untouched.
- Full queue 0: push 0x55 and pop together → count stays 4, no overflow. 0x55 is popped last, confirming wrap-around of both pointers.
- Empty queue 2: pop → underflow=1, count=0. Push+pop together → count=1, value_out=pushed data. `clear_errors` → underflow=0.
- higher=3, lower=1 on queue 3: push 3 → kill=1 on the edge after the 3rd push. Pop 1 → kill stays 1 at count 2. Pop 1 more → kill=0 at count 1. Set higher=0 → kill=0 at the next edge.
- Assert reset mid-stream with pushes pending on all queues → all state matches the reset values the cycle after, and the pending pushes are discarded.
